cla_burst_accumulator: RTL and testbench

CLA_BURST_ACCUMULATOR -- requirements
Module: cla_burst_accumulator

---
 rtl/cla_burst_accumulator.sv | 135 +++++++++++++
 tb/tb_cla_burst_accumulator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cla_burst_accumulator.sv
// Burst accumulator: sums COUNT operands through a carry-lookahead adder and
// holds the result, with a sticky carry-out flag, until the consumer takes it.

module Carry_LookAhead_Adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_add1 & i_add2;
  assign w_p = i_add1 ^ i_add2;

  // Each carry is the fully expanded generate/propagate product, so no carry
  // depends on a lower computed carry.
  always_comb begin
    logic v_term;
    logic v_prod;
    w_c    = '0;
    v_term = 1'b0;
    v_prod = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      v_term = w_g[i];
      v_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        v_term = v_term | (v_prod & w_g[j]);
        v_prod = v_prod & w_p[j];
      end
      w_c[i+1] = v_term;
    end
  end

  assign o_result = {w_c[WIDTH], w_p ^ w_c[WIDTH-1:0]};
endmodule

// state | meaning
// IDLE  | waiting for i_start; outputs not valid
// ACCUM | accepting operands until COUNT have been added
// HOLD  | result valid, waiting for i_ready
module cla_burst_accumulator #(
  parameter int WIDTH = 3,
  parameter int COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow,
  output logic             o_busy
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_valid;
  logic             r_busy;
  logic [WIDTH:0]   w_result;

  Carry_LookAhead_Adder #(.WIDTH(WIDTH)) u_cla (
    .i_add1   (r_acc),
    .i_add2   (i_data),
    .o_result (w_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (i_valid && r_ready) begin
            r_acc <= w_result[WIDTH-1:0];
            r_ovf <= r_ovf | w_result[WIDTH];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state <= HOLD;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_sum      = r_acc;
  assign o_overflow = r_ovf;
endmodule

// File: tb/tb_cla_burst_accumulator.sv
// Directed bench for cla_burst_accumulator with a running-total reference
// model compared every cycle plus literal expectations per scenario.

module tb_cla_burst_accumulator;
  localparam int W = 3;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         valid = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] data = '0;
  logic         o_ready, o_valid, o_overflow, o_busy;
  logic [W-1:0] o_sum;

  int  total_n = 0;
  int  bad_n = 0;
  bit  chk_en = 1'b0;

  // reference: phase 0=idle 1=accepting 2=result held; unwrapped running total
  int  m_phase = 0;
  int  m_total = 0;
  int  m_n = 0;

  cla_burst_accumulator #(.WIDTH(W), .COUNT(C)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_valid    (valid),
    .i_data     (data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_sum      (o_sum),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_total = 0; m_n = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_total = 0; m_n = 0; end
        1: if (valid) begin
             m_total = m_total + int'(data);
             m_n++;
             if (m_n == C) m_phase = 2;
           end
        default: if (rdy) m_phase = 0;
      endcase
    end
  end

  // A carry occurs exactly when the unwrapped total first reaches 2^W,
  // since the running total never decreases within a burst.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready", int'(o_ready), int'(m_phase == 1));
      check("model_valid", int'(o_valid), int'(m_phase == 2));
      check("model_busy",  int'(o_busy),  int'(m_phase != 0));
      check("model_sum",   int'(o_sum),   m_total % (1 << W));
      check("model_ovf",   int'(o_overflow), int'(m_total >= (1 << W)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int ops[4], input int gap);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = W'(ops[i]);
      cyc();
      valid = 1'b0;
      if (i < 3) repeat (gap) cyc();
    end
  endtask

  task automatic release_result();
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    check("released_valid", int'(o_valid), 0);
    check("released_busy", int'(o_busy), 0);
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_ready", int'(o_ready), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_sum", int'(o_sum), 0);
    rst = 1'b0;
    cyc();

    run_burst('{1, 2, 1, 2}, 0);
    check("basic_valid_lat1", int'(o_valid), 1);
    check("basic_sum", int'(o_sum), 6);
    check("basic_ovf", int'(o_overflow), 0);
    release_result();

    run_burst('{7, 7, 1, 0}, 0);
    check("carry_sum", int'(o_sum), 7);
    check("carry_ovf", int'(o_overflow), 1);
    rdy = 1'b0; valid = 1'b1; start = 1'b1; data = 3'd5;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("bp_valid", int'(o_valid), 1);
      check("bp_sum", int'(o_sum), 7);
      check("bp_ready", int'(o_ready), 0);
    end
    valid = 1'b0; start = 1'b0;
    release_result();

    run_burst('{3, 0, 2, 1}, 2);
    check("gap_valid", int'(o_valid), 1);
    check("gap_sum", int'(o_sum), 6);
    release_result();

    start = 1'b1;
    cyc();
    start = 1'b0;
    valid = 1'b1; data = 3'd1;
    repeat (2) cyc();
    rst = 1'b1; start = 1'b1; rdy = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0; rdy = 1'b0; valid = 1'b0;
    check("rst_sum", int'(o_sum), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_ready), 0);
    cyc();
    check("rst_no_valid", int'(o_valid), 0);
    run_burst('{1, 1, 1, 1}, 0);
    check("after_rst_sum", int'(o_sum), 4);
    check("after_rst_ovf", int'(o_overflow), 0);
    release_result();

    start = 1'b1; valid = 1'b1; data = 3'd7;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 3'd1;
      cyc();
      check("coll_not_done", int'(o_valid), 0);
    end
    cyc();
    valid = 1'b0;
    check("coll_valid", int'(o_valid), 1);
    check("coll_sum", int'(o_sum), 4);
    check("coll_ovf", int'(o_overflow), 0);
    release_result();
    cyc();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
